// File: rtl/vcmp_pkg.sv
// Shared types, default widths and the saturating counter helper for the
// vector-compare scoreboard.
package vcmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int F0W_D = 3;
  localparam int F1W_D = 1;
  localparam int F2W_D = 6;
  localparam int CW_D  = 16;

  // Increment that sticks at the all-ones value of a w-bit counter (w <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = {64{1'b1}} >> (64 - w);
    return (v >= max_v) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/vcmp_field_stat.sv
// Saturating mismatch counter for one output field of the compared vector.
module vcmp_field_stat
  import vcmp_pkg::*;
#(
  parameter int CW = CW_D
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          en,
  input  logic          mism,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && mism) begin
      count <= CW'(sat_inc(64'(count), CW));
    end
  end

endmodule

// File: rtl/vcmp_scoreboard.sv
// Response checker: compares ref/dut vectors per field, keeps run statistics
// and holds a pass/fail verdict from stop until the next start.
module vcmp_scoreboard
  import vcmp_pkg::*;
#(
  parameter int F0W = F0W_D,
  parameter int F1W = F1W_D,
  parameter int F2W = F2W_D,
  parameter int CW  = CW_D
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   smp_valid,
  input  logic [F0W+F1W+F2W-1:0] ref_vec,
  input  logic [F0W+F1W+F2W-1:0] dut_vec,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [CW-1:0]          samples,
  output logic [CW-1:0]          errors,
  output logic [CW-1:0]          err_f0,
  output logic [CW-1:0]          err_f1,
  output logic [CW-1:0]          err_f2,
  output logic [CW-1:0]          first_err,
  output logic                   any_err,
  output state_t                 state
);

  localparam int VW = F0W + F1W + F2W;

  logic          m0, m1, m2, any_m, en;
  logic [CW-1:0] errors_n;

  assign m0    = ref_vec[VW-1 -: F0W] != dut_vec[VW-1 -: F0W];
  assign m1    = ref_vec[F2W +: F1W] != dut_vec[F2W +: F1W];
  assign m2    = ref_vec[F2W-1:0] != dut_vec[F2W-1:0];
  assign any_m = m0 | m1 | m2;
  // A sample arriving with start is discarded; one arriving with stop counts.
  assign en    = (state == ST_RUN) && smp_valid && !start;

  // Error count including this cycle's sample, so pass can be decided on stop.
  always_comb begin
    errors_n = errors;
    if (en && any_m) errors_n = CW'(sat_inc(64'(errors), CW));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      samples   <= '0;
      errors    <= '0;
      first_err <= '0;
      any_err   <= 1'b0;
    end else if (start) begin
      state     <= ST_RUN;
      busy      <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
      samples   <= '0;
      errors    <= '0;
      first_err <= '0;
      any_err   <= 1'b0;
    end else begin
      if (en) begin
        samples <= CW'(sat_inc(64'(samples), CW));
        errors  <= errors_n;
        if (any_m && !any_err) begin
          first_err <= samples;
          any_err   <= 1'b1;
        end
      end
      if (state == ST_RUN && stop) begin
        state <= ST_DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        pass  <= (errors_n == '0);
      end
    end
  end

  vcmp_field_stat #(.CW(CW)) u_f0 (
    .clk(clk), .resetn(resetn), .clr(start), .en(en), .mism(m0), .count(err_f0)
  );
  vcmp_field_stat #(.CW(CW)) u_f1 (
    .clk(clk), .resetn(resetn), .clr(start), .en(en), .mism(m1), .count(err_f1)
  );
  vcmp_field_stat #(.CW(CW)) u_f2 (
    .clk(clk), .resetn(resetn), .clr(start), .en(en), .mism(m2), .count(err_f2)
  );

endmodule
